zap_shifter_arb: RTL and testbench

ZAP_SHIFTER_ARB -- requirements
Module: zap_shifter_arb

---
 rtl/zap_shifter_arb_pkg.sv | 25 ++
 rtl/zap_shifter_shift.sv | 139 +++++++++++++
 rtl/zap_shifter_arb.sv | 111 +++++++++++
 tb/tb_zap_shifter_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_shifter_arb_pkg.sv
// ============================================================================
// zap_shifter_arb_pkg : shared shift opcodes and arbiter FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package zap_shifter_arb_pkg;

  localparam logic [2:0] LSL     = 3'd0;
  localparam logic [2:0] LSR     = 3'd1;
  localparam logic [2:0] ASR     = 3'd2;
  localparam logic [2:0] ROR     = 3'd3;
  localparam logic [2:0] RORI    = 3'd4;
  localparam logic [2:0] ROR_1   = 3'd5;
  localparam logic [2:0] RRC     = 3'd6;
  localparam logic [2:0] LSL_SAT = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/zap_shifter_shift.sv
// ============================================================================
// zap_shifter_shift : combinational 32-bit barrel shifter with carry/sat/err
// LSL_SAT is only implemented when ZAP_SHIFTER_ARB_SAT_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module zap_shifter_shift
  import zap_shifter_arb_pkg::*;
#(
  parameter int TW = 3
) (
  input  logic [31:0]   source_i,
  input  logic [7:0]    amount_i,
  input  logic          carry_i,
  input  logic [TW-1:0] type_i,
  output logic [31:0]   result_o,
  output logic          carry_o,
  output logic          sat_o,
  output logic          err_o
);

  logic [2:0]  w_op;
  logic        w_op_hi;
  logic [63:0] w_t64;
`ifdef ZAP_SHIFTER_ARB_SAT_EN
  logic [63:0] w_p64;
  logic        w_ovf;
`endif

  // Any opcode bit above the 3-bit defined range makes the code illegal.
  generate
    if (TW > 3) begin : g_op_wide
      assign w_op    = type_i[2:0];
      assign w_op_hi = |type_i[TW-1:3];
    end else if (TW == 3) begin : g_op_exact
      assign w_op    = type_i;
      assign w_op_hi = 1'b0;
    end else begin : g_op_narrow
      assign w_op    = 3'(type_i);
      assign w_op_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    w_t64    = '0;
`ifdef ZAP_SHIFTER_ARB_SAT_EN
    w_p64    = '0;
    w_ovf    = 1'b0;
`endif
    result_o = 32'h0;
    carry_o  = carry_i;
    sat_o    = 1'b0;
    err_o    = 1'b0;
    if (w_op_hi) begin
      err_o = 1'b1;
    end else begin
      case (w_op)
        LSL: begin
          if (amount_i == 8'd0) begin
            result_o = source_i;
          end else if (amount_i <= 8'd32) begin
            w_t64    = {32'h0, source_i} << amount_i[5:0];
            result_o = w_t64[31:0];
            carry_o  = w_t64[32];
          end else begin
            carry_o = 1'b0;
          end
        end
        LSR: begin
          if (amount_i == 8'd0) begin
            result_o = source_i;
          end else if (amount_i <= 8'd32) begin
            w_t64    = {source_i, 32'h0} >> amount_i[5:0];
            result_o = w_t64[63:32];
            carry_o  = w_t64[31];
          end else begin
            carry_o = 1'b0;
          end
        end
        ASR: begin
          if (amount_i == 8'd0) begin
            result_o = source_i;
          end else if (amount_i < 8'd32) begin
            w_t64    = $signed({source_i, 32'h0}) >>> amount_i[4:0];
            result_o = w_t64[63:32];
            carry_o  = w_t64[31];
          end else begin
            result_o = {32{source_i[31]}};
            carry_o  = source_i[31];
          end
        end
        ROR: begin
          if (amount_i == 8'd0) begin
            result_o = source_i;
          end else begin
            w_t64    = {source_i, source_i} >> amount_i[4:0];
            result_o = w_t64[31:0];
            carry_o  = w_t64[31];
          end
        end
        RORI: begin
          // Immediate form rotates by twice the low nibble.
          w_t64    = {source_i, source_i} >> {amount_i[3:0], 1'b0};
          result_o = w_t64[31:0];
          if (amount_i[3:0] != 4'd0) carry_o = w_t64[31];
        end
        ROR_1: begin
          result_o = {source_i[0], source_i[31:1]};
          carry_o  = source_i[0];
        end
        RRC: begin
          result_o = {carry_i, source_i[31:1]};
          carry_o  = source_i[0];
        end
`ifdef ZAP_SHIFTER_ARB_SAT_EN
        LSL_SAT: begin
          if (amount_i == 8'd0) begin
            result_o = source_i;
          end else begin
            w_p64 = {{32{source_i[31]}}, source_i} << amount_i[4:0];
            if (amount_i >= 8'd32) w_ovf = (source_i != 32'h0);
            else                   w_ovf = !((&w_p64[63:31]) || !(|w_p64[63:31]));
            if (w_ovf) begin
              result_o = source_i[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              sat_o    = 1'b1;
            end else if (amount_i < 8'd32) begin
              result_o = w_p64[31:0];
            end
          end
        end
`endif
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/zap_shifter_arb.sv
// ============================================================================
// zap_shifter_arb : two-requester round-robin front end with one-entry response
// buffer around zap_shifter_shift; ZAP_SHIFTER_ARB_SAT_EN enables LSL_SAT. Rev 1.0
// ============================================================================
`default_nettype none

module zap_shifter_arb
  import zap_shifter_arb_pkg::*;
#(
  parameter int SHIFT_OPS = 32'd5,
  parameter int NREQ      = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic [NREQ-1:0]                        i_req_valid,
  output logic [NREQ-1:0]                        o_req_ready,
  input  logic [NREQ-1:0][31:0]                  i_req_source,
  input  logic [NREQ-1:0][7:0]                   i_req_amount,
  input  logic [NREQ-1:0]                        i_req_carry,
  input  logic [NREQ-1:0][$clog2(SHIFT_OPS)-1:0] i_req_type,
  output logic [NREQ-1:0]                        o_rsp_valid,
  input  logic [NREQ-1:0]                        i_rsp_ready,
  output logic [31:0]                            o_rsp_result,
  output logic                                   o_rsp_carry,
  output logic                                   o_rsp_sat,
  output logic                                   o_rsp_err
);

  localparam int TW = $clog2(SHIFT_OPS);

  state_e            state_q;
  logic              ptr_q;
  logic              owner_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [31:0]       result_q;
  logic              carry_q;
  logic              sat_q;
  logic              err_q;

  logic              w_can_accept;
  logic              w_gnt_any;
  logic              w_gnt_idx;
  logic              w_xfer;
  logic              w_drain;
  logic [31:0]       w_sh_result;
  logic              w_sh_carry;
  logic              w_sh_sat;
  logic              w_sh_err;

  // A full buffer frees itself for a new grant only when its owner takes the response.
  assign w_can_accept = !i_reset && ((state_q == IDLE) || i_rsp_ready[owner_q]);
  assign w_gnt_any    = i_req_valid[ptr_q] || i_req_valid[~ptr_q];
  assign w_gnt_idx    = i_req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign w_xfer       = w_can_accept && w_gnt_any;
  assign w_drain      = (state_q == HOLD) && i_rsp_ready[owner_q];

  assign o_req_ready[0] = w_xfer && !w_gnt_idx;
  assign o_req_ready[1] = w_xfer &&  w_gnt_idx;

  zap_shifter_shift #(
    .TW (TW)
  ) u_shift (
    .source_i (i_req_source[w_gnt_idx]),
    .amount_i (i_req_amount[w_gnt_idx]),
    .carry_i  (i_req_carry[w_gnt_idx]),
    .type_i   (i_req_type[w_gnt_idx]),
    .result_o (w_sh_result),
    .carry_o  (w_sh_carry),
    .sat_o    (w_sh_sat),
    .err_o    (w_sh_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      rsp_valid_q <= '0;
      result_q    <= 32'h0;
      carry_q     <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (w_xfer) begin
      state_q        <= HOLD;
      ptr_q          <= ~w_gnt_idx;
      owner_q        <= w_gnt_idx;
      rsp_valid_q    <= '0;
      rsp_valid_q[w_gnt_idx] <= 1'b1;
      result_q       <= w_sh_result;
      carry_q        <= w_sh_carry;
      sat_q          <= w_sh_sat;
      err_q          <= w_sh_err;
    end else if (w_drain) begin
      state_q     <= IDLE;
      rsp_valid_q <= '0;
      result_q    <= 32'h0;
      carry_q     <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = result_q;
  assign o_rsp_carry  = carry_q;
  assign o_rsp_sat    = sat_q;
  assign o_rsp_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_zap_shifter_arb.sv
// ============================================================================
// tb_zap_shifter_arb : directed and random checks of zap_shifter_arb against a
// transaction-level reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_zap_shifter_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] src;
  logic [1:0][7:0]  amt;
  logic [1:0]       cin;
  logic [1:0][2:0]  typ;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_carry;
  logic             rsp_sat;
  logic             rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: at most one outstanding response plus the favoured requester.
  bit          m_pend  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_ptr   = 1'b0;
  logic [31:0] m_res   = 32'h0;
  bit          m_c, m_s, m_e;

  always #5 clk = ~clk;

  zap_shifter_arb #(
    .SHIFT_OPS (32'd5),
    .NREQ      (2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_source (src),
    .i_req_amount (amt),
    .i_req_carry  (cin),
    .i_req_type   (typ),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_carry  (rsp_carry),
    .o_rsp_sat    (rsp_sat),
    .o_rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_shift(input int op, input logic [31:0] s, input int a, input bit ci,
                                    output logic [31:0] r, output bit co, output bit so, output bit eo);
    logic [63:0] u;
    longint      sv;
    int          n;
    r = 32'h0; co = ci; so = 1'b0; eo = 1'b0;
    case (op)
      0: begin
        if (a == 0) r = s;
        else if (a <= 32) begin u = 64'(s) * (64'd1 << a); r = u[31:0]; co = u[32]; end
        else co = 1'b0;
      end
      1: begin
        if (a == 0) r = s;
        else if (a <= 32) begin r = 32'(64'(s) >> a); co = s[a-1]; end
        else co = 1'b0;
      end
      2: begin
        sv = longint'($signed(s));
        if (a == 0) r = s;
        else if (a < 32) begin r = 32'(sv >>> a); co = s[a-1]; end
        else begin r = {32{s[31]}}; co = s[31]; end
      end
      3: begin
        if (a == 0) r = s;
        else begin
          n = a % 32; r = s;
          for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
          co = r[31];
        end
      end
      4: begin
        n = 2 * (a % 16); r = s;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        co = (n == 0) ? ci : r[31];
      end
      5: begin r = {s[0], s[31:1]}; co = s[0]; end
      6: begin r = {ci, s[31:1]};   co = s[0]; end
      7: begin
`ifdef ZAP_SHIFTER_ARB_SAT_EN
        sv = longint'($signed(s));
        if (a == 0) r = s;
        else if (a >= 32) begin
          if (s != 32'h0) begin so = 1'b1; r = s[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; end
        end else begin
          sv = sv * (longint'(1) << a);
          if (sv > 64'sd2147483647)       begin so = 1'b1; r = 32'h7FFF_FFFF; end
          else if (sv < -64'sd2147483648) begin so = 1'b1; r = 32'h8000_0000; end
          else r = sv[31:0];
        end
`else
        eo = 1'b1;
`endif
      end
      default: eo = 1'b1;
    endcase
  endfunction

  task automatic set_req(input int r, input int op, input logic [31:0] s, input logic [7:0] a, input bit c);
    typ[r] = op[2:0];
    src[r] = s;
    amt[r] = a;
    cin[r] = c;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances the model over one rising edge.
  task automatic cycle();
    logic [1:0] e_ready;
    bit         g_ok;
    bit         g_idx;
    #1;
    e_ready = 2'b00; g_ok = 1'b0; g_idx = 1'b0;
    if (!rst && !(m_pend && !rsp_ready[m_owner])) begin
      if (req_valid[m_ptr])       begin g_ok = 1'b1; g_idx = m_ptr;  end
      else if (req_valid[!m_ptr]) begin g_ok = 1'b1; g_idx = !m_ptr; end
    end
    if (g_ok) e_ready[g_idx] = 1'b1;
    chk("req_ready",  32'(req_ready),  32'(e_ready));
    chk("rsp_valid",  32'(rsp_valid),  m_pend ? (32'd1 << m_owner) : 32'd0);
    chk("rsp_result", rsp_result,      m_pend ? m_res : 32'h0);
    chk("rsp_carry",  32'(rsp_carry),  32'(m_pend & m_c));
    chk("rsp_sat",    32'(rsp_sat),    32'(m_pend & m_s));
    chk("rsp_err",    32'(rsp_err),    32'(m_pend & m_e));
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0; m_ptr = 1'b0;
    end else if (g_ok) begin
      ref_shift(int'(typ[g_idx]), src[g_idx], int'(amt[g_idx]), cin[g_idx], m_res, m_c, m_s, m_e);
      m_pend = 1'b1; m_owner = g_idx; m_ptr = !g_idx;
    end else if (m_pend && rsp_ready[m_owner]) begin
      m_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    src = '0; amt = '0; cin = '0; typ = '0;
    @(negedge clk);
    cycle();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data",  rsp_result,     32'h0);
    cycle();
    rst = 1'b0; req_valid = 2'b00;

    // LSL 1 << 4 on requester 0
    req_valid = 2'b01; set_req(0, 0, 32'h0000_0001, 8'd4, 1'b0);
    cycle();
    req_valid = 2'b00;
    #1;
    chk("lsl_valid", 32'(rsp_valid), 32'h1);
    chk("lsl_res",   rsp_result,     32'h0000_0010);
    chk("lsl_carry", 32'(rsp_carry), 32'h0);
    cycle();

    // Round-robin from a fresh reset
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    set_req(0, 1, 32'hF0F0_0000, 8'd8, 1'b0);
    set_req(1, 6, 32'h0000_0003, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      cycle();
    end
    req_valid = 2'b00; cycle();

    // ASR with a stalled owner; owner-0 ready must be ignored
    req_valid = 2'b10; set_req(1, 2, 32'h8000_0000, 8'd31, 1'b0); rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b11; rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("asr_stall_valid", 32'(rsp_valid), 32'h2);
      chk("asr_stall_res",   rsp_result,     32'hFFFF_FFFF);
      chk("asr_stall_ready", 32'(req_ready), 32'h0);
      cycle();
    end
    req_valid = 2'b00; rsp_ready = 2'b10;
    #1;
    chk("asr_deliver", 32'(rsp_valid), 32'h2);
    cycle();
    #1;
    chk("asr_drained", 32'(rsp_valid), 32'h0);
    rsp_ready = 2'b11;

    // Saturating shift
    req_valid = 2'b01; set_req(0, 7, 32'h4000_0000, 8'd1, 1'b0);
    cycle();
    req_valid = 2'b00;
    #1;
`ifdef ZAP_SHIFTER_ARB_SAT_EN
    chk("sat_res", rsp_result,     32'h7FFF_FFFF);
    chk("sat_sat", 32'(rsp_sat),   32'h1);
    chk("sat_err", 32'(rsp_err),   32'h0);
`else
    chk("sat_res", rsp_result,     32'h0);
    chk("sat_sat", 32'(rsp_sat),   32'h0);
    chk("sat_err", 32'(rsp_err),   32'h1);
`endif
    cycle();

    // ROR 1 by 1
    req_valid = 2'b10; set_req(1, 3, 32'h0000_0001, 8'd1, 1'b0);
    cycle();
    req_valid = 2'b00;
    #1;
    chk("ror_res",   rsp_result,     32'h8000_0000);
    chk("ror_carry", 32'(rsp_carry), 32'h1);
    cycle();

    // Reset while holding: response dropped, pointer back at 0
    req_valid = 2'b01; set_req(0, 0, 32'h0000_00A5, 8'd2, 1'b0); rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b00; cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rsthold_valid", 32'(rsp_valid), 32'h0);
    chk("rsthold_ptr",   32'(req_ready), 32'h1);
    cycle();
    rsp_ready = 2'b11; req_valid = 2'b00; cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      for (int r = 0; r < 2; r++) begin
        set_req(r, int'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40)),
                1'($urandom));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
